// File: rtl/serial_add_sub_pkg.sv
// serial_add_sub_pkg: shared FSM encoding and sizing helpers for serial_add_sub.
// No ports. Imported by serial_add_sub.
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A counter over a single chunk still needs one bit to be a legal vector.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: operand/result handshake bundle for serial_add_sub.
// Signals: in_valid/in_ready/a/b/sub (operation request),
//          out_valid/out_ready/result/cout/overflow (result handoff).
// Modports: master drives requests and consumes results; slave is the adder.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, cout, overflow
    );
endinterface

// File: rtl/serial_add_sub_chunk_adder.sv
// chunk_adder: CHUNK-bit ripple of full adders.
// Ports: a_i, b_i (CHUNK-bit addends), cin_i (carry in),
//        sum_o (CHUNK-bit sum), cout_o (carry out of top bit),
//        c_msb_o (carry into top bit, used for signed overflow).
module chunk_adder #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             c_msb_o
);
    logic c;

    always_comb begin
        c       = cin_i;
        c_msb_o = cin_i;
        sum_o   = '0;
        for (int i = 0; i < CHUNK; i++) begin
            c_msb_o  = c;
            sum_o[i] = a_i[i] ^ b_i[i] ^ c;
            c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        cout_o = c;
    end
endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle adder/subtractor, CHUNK bits per clock, with carry and signed overflow.
// Ports: clk, rst_n (async active-low), bus (serial_add_sub_if.slave: request and result handshake).
// Optional: define SERIAL_ADD_SUB_SATURATE_EN to saturate the result on signed overflow.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input logic              clk,
    input logic              rst_n,
    serial_add_sub_if.slave  bus
);
    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int CW     = cnt_w(NCHUNK);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("serial_add_sub: WIDTH must be a multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] sum;
    logic             c_out;
    logic             c_msb;
    logic [WIDTH-1:0] fin;
    logic [WIDTH-1:0] res_fin;
    logic             last;

    chunk_adder #(.CHUNK(CHUNK)) u_add (
        .a_i     (opa_q[CHUNK-1:0]),
        .b_i     (opb_q[CHUNK-1:0]),
        .cin_i   (carry_q),
        .sum_o   (sum),
        .cout_o  (c_out),
        .c_msb_o (c_msb)
    );

    assign last = cnt_q == CW'(NCHUNK - 1);
    // New chunk enters at the top; after NCHUNK steps the LSB chunk has reached bit 0.
    assign fin  = WIDTH'({sum, sh_q} >> CHUNK);

`ifdef SERIAL_ADD_SUB_SATURATE_EN
    // Overflow implies both operands share A's sign, so A's MSB picks the rail.
    assign res_fin = (c_msb ^ c_out) ? {opa_q[CHUNK-1], {(WIDTH-1){~opa_q[CHUNK-1]}}} : fin;
`else
    assign res_fin = fin;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sh_d    = sh_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: if (bus.in_valid) begin
                opa_d   = bus.a;
                opb_d   = bus.sub ? ~bus.b : bus.b;
                carry_d = bus.sub;
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                sh_d    = fin;
                carry_d = c_out;
                opa_d   = opa_q >> CHUNK;
                opb_d   = opb_q >> CHUNK;
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    res_d   = res_fin;
                    cout_d  = c_out;
                    ovf_d   = c_msb ^ c_out;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = bus.out_ready ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            sh_q    <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sh_q    <= sh_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = state_q == ST_IDLE;
    assign bus.out_valid = state_q == ST_DONE;
    assign bus.result    = res_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: checks serial_add_sub at CHUNK=2, 1 and 8 (WIDTH=8) against an arithmetic model.
module tb_serial_add_sub;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic       sub = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_add_sub_if #(.WIDTH(8)) if0 ();
    serial_add_sub_if #(.WIDTH(8)) if1 ();
    serial_add_sub_if #(.WIDTH(8)) if2 ();

    assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;
    assign if0.out_ready = out_ready; assign if1.out_ready = out_ready; assign if2.out_ready = out_ready;
    assign if0.a = a;  assign if1.a = a;  assign if2.a = a;
    assign if0.b = b;  assign if1.b = b;  assign if2.b = b;
    assign if0.sub = sub; assign if1.sub = sub; assign if2.sub = sub;

    serial_add_sub #(.WIDTH(8), .CHUNK(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    serial_add_sub #(.WIDTH(8), .CHUNK(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    serial_add_sub #(.WIDTH(8), .CHUNK(8)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    logic       ir[3];
    logic       ov[3];
    logic [9:0] rv[3];
    assign ir[0] = if0.in_ready;  assign ov[0] = if0.out_valid;  assign rv[0] = {if0.cout, if0.overflow, if0.result};
    assign ir[1] = if1.in_ready;  assign ov[1] = if1.out_valid;  assign rv[1] = {if1.cout, if1.overflow, if1.result};
    assign ir[2] = if2.in_ready;  assign ov[2] = if2.out_valid;  assign rv[2] = {if2.cout, if2.overflow, if2.result};

    function automatic int lat(input int k);
        return (k == 0) ? 4 : (k == 1) ? 8 : 1;
    endfunction

    // Expected {cout, overflow, result} from plain integer arithmetic.
    function automatic logic [9:0] f(input logic [7:0] x, input logic [7:0] y, input logic s);
        int sx, sy, r;
        logic c, v;
        logic [7:0] q;
        sx = int'($signed(x));
        sy = int'($signed(y));
        r  = s ? sx - sy : sx + sy;
        c  = s ? (x >= y) : ((int'(x) + int'(y)) > 255);
        v  = (r > 127) || (r < -128);
        q  = r[7:0];
`ifdef SERIAL_ADD_SUB_SATURATE_EN
        if (v) q = (r > 0) ? 8'h7F : 8'h80;
`endif
        return {c, v, q};
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h expected %h", nm, k, got, exp);
        end
    endtask

    // Model: 0 idle, 1 busy counting down, 2 result waiting for handoff.
    int         m_st[3]   = '{0, 0, 0};
    int         m_cnt[3]  = '{0, 0, 0};
    logic [9:0] m_pend[3] = '{10'd0, 10'd0, 10'd0};
    logic [9:0] m_last[3] = '{10'd0, 10'd0, 10'd0};

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_st[k]   <= 0;
                m_cnt[k]  <= 0;
                m_last[k] <= 10'd0;
            end else if (m_st[k] == 0 && in_valid) begin
                m_st[k]   <= 1;
                m_cnt[k]  <= lat(k) - 1;
                m_pend[k] <= f(a, b, sub);
            end else if (m_st[k] == 1) begin
                if (m_cnt[k] == 0) begin
                    m_st[k]   <= 2;
                    m_last[k] <= m_pend[k];
                end else begin
                    m_cnt[k] <= m_cnt[k] - 1;
                end
            end else if (m_st[k] == 2 && out_ready) begin
                m_st[k] <= 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++)
            chk("cycle", k, {20'd0, ir[k], ov[k], rv[k]}, {20'd0, m_st[k] == 0, m_st[k] == 2, m_last[k]});
    end

    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic s);
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        a = x;
        b = y;
        sub = s;
        @(negedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic s, input logic [9:0] exp);
        issue(x, y, s);
        repeat (11) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk("op_result", k, {22'd0, rv[k]}, {22'd0, exp});
    endtask

`ifdef SERIAL_ADD_SUB_SATURATE_EN
    localparam logic [7:0] POS_OVF = 8'h7F;
    localparam logic [7:0] NEG_OVF = 8'h80;
`else
    localparam logic [7:0] POS_OVF = 8'h80;
    localparam logic [7:0] NEG_OVF = 8'h7F;
`endif

    initial begin
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk("reset", k, {20'd0, ir[k], ov[k], rv[k]}, {20'd0, 2'b10, 10'd0});
        rst_n = 1'b1;

        run_op(8'd100, 8'd27,  1'b0, {2'b00, 8'h7F});
        run_op(8'd100, 8'd28,  1'b0, {2'b01, POS_OVF});
        run_op(8'd5,   8'd7,   1'b1, {2'b00, 8'hFE});
        run_op(8'd7,   8'd5,   1'b1, {2'b10, 8'h02});
        run_op(8'h80,  8'h01,  1'b1, {2'b11, NEG_OVF});
        run_op(8'h7F,  8'hFF,  1'b1, {2'b01, POS_OVF});
        run_op(8'h55,  8'hAA,  1'b0, {2'b00, 8'hFF});

        out_ready = 1'b0;
        issue(8'd100, 8'd27, 1'b0);
        repeat (12) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk("stall_hold", k, {20'd0, ir[k], ov[k], rv[k]}, {20'd0, 2'b01, 10'h07F});
        issue(8'h01, 8'h01, 1'b0);
        repeat (10) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk("stall_ignore", k, {20'd0, ir[k], ov[k], rv[k]}, {20'd0, 2'b01, 10'h07F});
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk("release", k, {20'd0, ir[k], ov[k], rv[k]}, {20'd0, 2'b10, 10'h07F});

        issue(8'h10, 8'h20, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk("abort", k, {20'd0, ir[k], ov[k], rv[k]}, {20'd0, 2'b10, 10'd0});
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        run_op(8'hFF, 8'h01, 1'b0, {2'b10, 8'h00});

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Parametrised multi-cycle adder/subtractor with carry and signed-overflow flags.
- Processes CHUNK bits per clock through a ripple chunk of full adders, so one operation takes WIDTH/CHUNK cycles.
- Generalises the 8-bit combinational adder/subtractor to any width, with area/latency trade-off and a valid/ready handshake on both sides.
- Sits between operand registers and the result bus of the datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of CHUNK, otherwise elaboration error.
- CHUNK, 2, bits added per cycle; 1 gives bit-serial, WIDTH gives single-cycle.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and mode are valid
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0 = A+B, 1 = A-B
- out_valid  output  1  result and flags are valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  sum/difference
- cout  output  1  raw carry out of the MSB (for subtract, 1 = no borrow)
- overflow  output  1  signed (two's-complement) overflow

Behaviour:
- Reset: one clock and one asynchronously active-low reset, exactly as decided; rst_n=0 forces state IDLE immediately.
  - Reset values: in_ready=1, out_valid=0, result=0, cout=0, overflow=0; chunk counter, carry and shift registers all 0.
- NCHUNK = WIDTH/CHUNK.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at a clock edge:
    - latch a into opA;
    - latch (sub ? ~b : b) into opB;
    - set carry=sub;
    - clear the chunk counter;
    - go to RUN.
  - in_ready=0 in every state except IDLE.
- RUN, each cycle:
  - add opA[CHUNK-1:0] + opB[CHUNK-1:0] + carry;
  - shift the chunk sum into the top of the result register (LSB chunk first);
  - update carry and shift opA/opB right by CHUNK;
  - increment the counter.
  - On the last chunk (counter = NCHUNK-1):
    - capture cout = final carry;
    - capture overflow = carry into MSB XOR carry out of MSB;
    - go to DONE.
- Latency: out_valid rises exactly NCHUNK clock edges after the accepting edge.
- DONE:
  - out_valid=1; result/cout/overflow held stable while out_ready=0, with unlimited backpressure.
  - On out_ready=1: go to IDLE and drop out_valid the next cycle. result/flags keep their last value until the next completion.
- Back-to-back: a new operation cannot be accepted in the same cycle as a result handoff; minimum issue interval is NCHUNK+2 cycles.
- Input changes: a/b/sub changing while not in IDLE are ignored.
- Reset mid-operation: asynchronous abort to IDLE; the pending result is discarded and out_valid=0.
- Wrap-around: result is modulo 2^WIDTH; cout and overflow are reported independently.
- CHUNK=WIDTH: single RUN cycle, latency 1.

Optional Feature:
- Macro: SERIAL_ADD_SUB_SATURATE_EN.
- Defined: on signed overflow, result saturates.
  - Positive overflow (A sign = effective B sign = 0) -> 0111..1.
  - Negative overflow -> 1000..0.
  - The overflow flag is still asserted; cout is unchanged (raw).
  - Saturation is applied when entering DONE; latency is unchanged.
- Undefined: wrap-around result only; no saturation logic is synthesised.

Decomposition:
- Shared package serial_add_sub_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - function/macro for NCHUNK;
  - counter width = clog2(NCHUNK), minimum 1.
- One natural sub-module: chunk_adder, a CHUNK-bit ripple of full adders.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and c_msb (carry into the top bit) for overflow detection.
  - Instantiated once; its outputs are registered by serial_add_sub.

Test Plan (WIDTH=8, CHUNK=2 unless noted):
- Add without overflow: a=100, b=27, sub=0 -> after 4 cycles out_valid=1, result=0x7F, cout=0, overflow=0.
- Add with overflow: a=100, b=28, sub=0 -> result=0x80, overflow=1, cout=0. With SERIAL_ADD_SUB_SATURATE_EN: result=0x7F, overflow=1.
- Subtract with borrow: a=5, b=7, sub=1 -> result=0xFE, cout=0, overflow=0. Then a=7, b=5, sub=1 -> result=0x02, cout=1.
- Negative overflow: a=0x80, b=0x01, sub=1 -> result=0x7F, overflow=1, cout=1. With SERIAL_ADD_SUB_SATURATE_EN: result=0x80.
- Backpressure and ignore: hold out_ready=0 for 10 cycles -> result/flags stable and in_ready=0. A second in_valid pulse during the stall is not accepted. out_ready=1 -> IDLE next cycle with in_ready=1.
- Reset mid-RUN, plus extremes:
  - Drop rst_n two cycles after acceptance -> out_valid=0, in_ready=1, result=0 immediately. After release, a fresh op 0xFF+0x01 -> result=0x00, cout=1, overflow=0.
  - Repeat with CHUNK=1 (8-cycle latency) and CHUNK=8 (1-cycle latency).
